jtag_port_arbiter: RTL and testbench
====================================

// Module: jtag_port_arbiter
// PURPOSE
// Shares one jtag_engine between two command sources: s0 = host UART RX/TX FIFOs, s1 = on-chip scan requester.
// Each source sends bursts: one header byte P (number of byte-pairs), then 2*P command bytes ({TMS[3:0],TDI[3:0]}).
// Sits between the sources' FIFOs and the engine. Presents a FIFO-like read port and a write port to the engine.
// Routes the P returned TDO bytes back to the source that owns the burst, then re-arbitrates.
// PARAMETERS
// FAIR    1  1 = round-robin between s0/s1; 0 = fixed priority, s0 wins every tie
// LEN_W   8  header width (= byte width); command counter is LEN_W+1 bits, return counter LEN_W bits
// PORTS
// clk            in   1  system clock
// rst            in   1  asynchronous reset, active-high
// s0_rx_empty    in   1  s0 command FIFO empty
// s0_rx_rd_en    out  1  s0 command FIFO read strobe (data valid next cycle)
// s0_rx_rd_data  in   8  s0 command FIFO data
// s0_tx_full     in   1  s0 return FIFO full
// s0_tx_wr_en    out  1  s0 return FIFO write strobe
// s0_tx_wr_data  out  8  s0 return data
// s1_*           --  --  identical set for s1
// eng_rx_empty   out  1  to engine rx_empty
// eng_rx_rd_en   in   1  from engine rx_rd_en
// eng_rx_rd_data out  8  to engine rx_rd_data
// eng_tx_full    out  1  to engine tx_full
// eng_tx_wr_en   in   1  from engine tx_wr_en
// eng_tx_wr_data in   8  from engine tx_wr_data
// busy           out  1  burst in progress (state != IDLE)
// owner          out  1  current/last granted source
// err            out  1  sticky: engine write with no return outstanding
// BEHAVIOUR
// - Registers: state, owner, last (last granted, reset 1), cmd_cnt, ret_cnt, err. Reset: IDLE, owner=0, counters 0, err=0.
// - Outputs in reset/IDLE: all rd_en/wr_en = 0, eng_rx_empty = 1, eng_tx_full = 1, busy = 0.
// - FSM IDLE -> HDR_RD -> HDR_CAP -> GRANT -> IDLE.
// - IDLE: if any sX_rx_empty = 0, pick a winner, latch owner, go to HDR_RD.
//   - Only one requesting: that one wins.
//   - Both requesting: FAIR=1 -> !last; FAIR=0 -> s0.
// - HDR_RD: sOWNER_rx_rd_en = 1 for exactly one cycle (combinational); go to HDR_CAP.
// - HDR_CAP: P = sOWNER_rx_rd_data; last <= owner.
//   - P == 0: header dropped, no grant, back to IDLE.
//   - Else: cmd_cnt = 2*P, ret_cnt = P, go to GRANT.
// - GRANT read path (combinational):
//   - eng_rx_empty = sOWNER_rx_empty | (cmd_cnt == 0).
//   - sOWNER_rx_rd_en = eng_rx_rd_en & (cmd_cnt != 0).
//   - eng_rx_rd_data = sOWNER_rx_rd_data; owner is stable all burst, so data read one cycle later is correct.
//   - cmd_cnt-- on each forwarded rd_en.
// - GRANT return path:
//   - eng_tx_full = sOWNER_tx_full.
//   - sOWNER_tx_wr_en = eng_tx_wr_en & (ret_cnt != 0); wr_data passed through.
//   - ret_cnt-- on each forwarded write.
// - GRANT exit: cmd_cnt == 0 and ret_cnt == 0 (after updates) -> IDLE next cycle. Read and return may decrement in the same cycle.
// - Non-owner source: rd_en = 0, wr_en = 0 always; its empty/full inputs are ignored.
// - eng_tx_wr_en while ret_cnt == 0 (any state): dropped, err <= 1 (cleared only by rst).
// - Source empty mid-burst: eng_rx_empty = 1, grant held indefinitely; no timeout.
// - Reset mid-burst: immediate return to IDLE, counters cleared. The engine shares rst, so no partial nibble survives.
// - Latency: header to first eng_rx_empty = 0 is 3 cycles from IDLE detection (IDLE, HDR_RD, HDR_CAP).
// TESTING
// - s0: 0x02,0x5A,0x5A,0x00,0xFF; engine model -> 4 eng reads; 2 writes land on s0_tx only; busy falls after 2nd write.
// - s0 and s1 both non-empty at reset, FAIR=1 -> s0 burst first, then s1; FAIR=0 with s0 holding 2 bursts -> s0, s0, s1.
// - s1 header 0x00 -> one s1 read, no eng reads, last=1, next tie goes to s0.
// - s0 header 0x01, only 1 cmd byte queued -> eng_rx_empty=1 after 1 read, s1 blocked; 2nd byte arrives -> burst completes.
// - s0 owner, s0_tx_full=1, s1_tx_full=0 -> eng_tx_full=1 until s0_tx_full drops; returned byte 0xC3 reaches s0.
// - eng_tx_wr_en pulsed in IDLE -> err=1, no sX_tx_wr_en; rst asserted mid-GRANT -> IDLE, busy=0, err=0.

Source files
------------

// File: rtl/jtag_port_arbiter.sv
// Arbitrates one JTAG engine between two byte-stream command sources (s0, s1).
// A burst is a header byte P followed by 2*P command bytes; P TDO bytes return to the burst's owner.
module jtag_port_arbiter #(
    parameter bit FAIR  = 1'b1,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_rx_empty,
    output logic             s0_rx_rd_en,
    input  logic [LEN_W-1:0] s0_rx_rd_data,
    input  logic             s0_tx_full,
    output logic             s0_tx_wr_en,
    output logic [LEN_W-1:0] s0_tx_wr_data,
    input  logic             s1_rx_empty,
    output logic             s1_rx_rd_en,
    input  logic [LEN_W-1:0] s1_rx_rd_data,
    input  logic             s1_tx_full,
    output logic             s1_tx_wr_en,
    output logic [LEN_W-1:0] s1_tx_wr_data,
    output logic             eng_rx_empty,
    input  logic             eng_rx_rd_en,
    output logic [LEN_W-1:0] eng_rx_rd_data,
    output logic             eng_tx_full,
    input  logic             eng_tx_wr_en,
    input  logic [LEN_W-1:0] eng_tx_wr_data,
    output logic             busy,
    output logic             owner,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR_RD  = 2'd1,
        ST_HDR_CAP = 2'd2,
        ST_GRANT   = 2'd3
    } state_t;

    localparam logic [LEN_W:0]   CMD_ZERO = {(LEN_W+1){1'b0}};
    localparam logic [LEN_W-1:0] RET_ZERO = {LEN_W{1'b0}};

    state_t           r_state, w_state_nxt;
    logic             r_owner, w_owner_nxt;
    logic             r_last, w_last_nxt;
    logic             r_err, w_err_nxt;
    logic [LEN_W:0]   r_cmd_cnt, w_cmd_nxt;
    logic [LEN_W-1:0] r_ret_cnt, w_ret_nxt;

    logic             w_own_empty;
    logic             w_own_full;
    logic [LEN_W-1:0] w_own_data;
    logic             w_winner;
    logic             w_src_rd;
    logic             w_rd_fwd;
    logic             w_wr_fwd;

    // Owner-side views of the source FIFOs and the tie-break winner.
    always_comb begin
        w_own_empty = r_owner ? s1_rx_empty   : s0_rx_empty;
        w_own_full  = r_owner ? s1_tx_full    : s0_tx_full;
        w_own_data  = r_owner ? s1_rx_rd_data : s0_rx_rd_data;
        if (!s0_rx_empty && !s1_rx_empty) begin
            w_winner = FAIR ? ~r_last : 1'b0;
        end else if (!s0_rx_empty) begin
            w_winner = 1'b0;
        end else begin
            w_winner = 1'b1;
        end
    end

    // Next-state logic and the combinational engine-facing handshakes.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_last_nxt   = r_last;
        w_cmd_nxt    = r_cmd_cnt;
        w_ret_nxt    = r_ret_cnt;
        w_src_rd     = 1'b0;
        w_rd_fwd     = 1'b0;
        w_wr_fwd     = 1'b0;
        eng_rx_empty = 1'b1;
        eng_tx_full  = 1'b1;
        // A return byte with nothing outstanding is dropped and flagged, whatever the state.
        w_err_nxt    = r_err | (eng_tx_wr_en & (r_ret_cnt == RET_ZERO));
        case (r_state)
            ST_IDLE: begin
                if (!s0_rx_empty || !s1_rx_empty) begin
                    w_owner_nxt = w_winner;
                    w_state_nxt = ST_HDR_RD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HDR_RD: begin
                w_src_rd    = 1'b1;
                w_state_nxt = ST_HDR_CAP;
            end
            ST_HDR_CAP: begin
                w_last_nxt = r_owner;
                if (w_own_data == RET_ZERO) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cmd_nxt   = {w_own_data, 1'b0};
                    w_ret_nxt   = w_own_data;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                eng_rx_empty = w_own_empty | (r_cmd_cnt == CMD_ZERO);
                eng_tx_full  = w_own_full;
                w_rd_fwd     = eng_rx_rd_en & (r_cmd_cnt != CMD_ZERO);
                w_wr_fwd     = eng_tx_wr_en & (r_ret_cnt != RET_ZERO);
                w_src_rd     = w_rd_fwd;
                w_cmd_nxt    = r_cmd_cnt - {{LEN_W{1'b0}}, w_rd_fwd};
                w_ret_nxt    = r_ret_cnt - {{(LEN_W-1){1'b0}}, w_wr_fwd};
                if ((w_cmd_nxt == CMD_ZERO) && (w_ret_nxt == RET_ZERO)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; last starts at s1 so the first tie goes to s0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_err     <= 1'b0;
            r_cmd_cnt <= CMD_ZERO;
            r_ret_cnt <= RET_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_err     <= w_err_nxt;
            r_cmd_cnt <= w_cmd_nxt;
            r_ret_cnt <= w_ret_nxt;
        end
    end

    assign s0_rx_rd_en    = w_src_rd & ~r_owner;
    assign s1_rx_rd_en    = w_src_rd &  r_owner;
    assign s0_tx_wr_en    = w_wr_fwd & ~r_owner;
    assign s1_tx_wr_en    = w_wr_fwd &  r_owner;
    assign s0_tx_wr_data  = eng_tx_wr_data;
    assign s1_tx_wr_data  = eng_tx_wr_data;
    assign eng_rx_rd_data = w_own_data;
    assign busy           = (r_state != ST_IDLE);
    assign owner          = r_owner;
    assign err            = r_err;

endmodule

// File: tb/tb_jtag_port_arbiter.sv
// Scoreboard bench for jtag_port_arbiter: a FAIR=1 and a FAIR=0 instance share one
// set of source FIFO models and one engine model; only the selected instance sees traffic.
`timescale 1ns/1ps
module tb_jtag_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int sel   = 0;

    // Source FIFO models (first-word registered read, like the real FIFOs).
    logic [7:0] mem [2][256];
    int         wp [2] = '{0, 0};
    int         rp [2] = '{0, 0};
    logic [7:0] src_data [2];
    logic       src_empty [2];
    logic       src_rd [2];
    logic       tx_full [2];

    assign src_empty[0] = (wp[0] == rp[0]);
    assign src_empty[1] = (wp[1] == rp[1]);

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (src_rd[s] && (wp[s] != rp[s])) begin
                src_data[s] <= mem[s][rp[s]];
                rp[s]       <= rp[s] + 1;
            end
        end
    end

    // Engine-side stimulus.
    logic       eng_en = 1'b0;
    logic       eng_rd = 1'b0;
    logic       eng_wr = 1'b0;
    logic [7:0] eng_wdata = 8'h00;
    logic       inject = 1'b0;
    int         eng_reads = 0;

    // Per-instance wiring, [inst][src].
    logic       k_rx_empty [2][2];
    logic       k_rd_en [2][2];
    logic       k_wr_en [2][2];
    logic [7:0] k_wr_data [2][2];
    logic       k_eng_rx_empty [2];
    logic       k_eng_rd_en [2];
    logic [7:0] k_eng_rd_data [2];
    logic       k_eng_tx_full [2];
    logic       k_eng_wr_en [2];
    logic       k_busy [2];
    logic       k_owner [2];
    logic       k_err [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            k_eng_rd_en[k] = (sel == k) ? eng_rd : 1'b0;
            k_eng_wr_en[k] = (sel == k) ? eng_wr : 1'b0;
            for (int s = 0; s < 2; s++) begin
                k_rx_empty[k][s] = (sel == k) ? src_empty[s] : 1'b1;
            end
        end
    end

    // View of the selected instance.
    logic       v_rd_en [2];
    logic       v_wr_en [2];
    logic [7:0] v_wr_data [2];
    logic       v_eng_rx_empty, v_eng_tx_full, v_busy, v_owner, v_err;
    logic [7:0] v_eng_rd_data;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            v_rd_en[s]   = (sel == 1) ? k_rd_en[1][s]   : k_rd_en[0][s];
            v_wr_en[s]   = (sel == 1) ? k_wr_en[1][s]   : k_wr_en[0][s];
            v_wr_data[s] = (sel == 1) ? k_wr_data[1][s] : k_wr_data[0][s];
            src_rd[s]    = v_rd_en[s];
        end
        v_eng_rx_empty = (sel == 1) ? k_eng_rx_empty[1] : k_eng_rx_empty[0];
        v_eng_tx_full  = (sel == 1) ? k_eng_tx_full[1]  : k_eng_tx_full[0];
        v_eng_rd_data  = (sel == 1) ? k_eng_rd_data[1]  : k_eng_rd_data[0];
        v_busy         = (sel == 1) ? k_busy[1]  : k_busy[0];
        v_owner        = (sel == 1) ? k_owner[1] : k_owner[0];
        v_err          = (sel == 1) ? k_err[1]   : k_err[0];
    end

    jtag_port_arbiter #(.FAIR(1'b1), .LEN_W(8)) u_fair (
        .clk(clk), .rst(rst),
        .s0_rx_empty(k_rx_empty[0][0]), .s0_rx_rd_en(k_rd_en[0][0]), .s0_rx_rd_data(src_data[0]),
        .s0_tx_full(tx_full[0]), .s0_tx_wr_en(k_wr_en[0][0]), .s0_tx_wr_data(k_wr_data[0][0]),
        .s1_rx_empty(k_rx_empty[0][1]), .s1_rx_rd_en(k_rd_en[0][1]), .s1_rx_rd_data(src_data[1]),
        .s1_tx_full(tx_full[1]), .s1_tx_wr_en(k_wr_en[0][1]), .s1_tx_wr_data(k_wr_data[0][1]),
        .eng_rx_empty(k_eng_rx_empty[0]), .eng_rx_rd_en(k_eng_rd_en[0]), .eng_rx_rd_data(k_eng_rd_data[0]),
        .eng_tx_full(k_eng_tx_full[0]), .eng_tx_wr_en(k_eng_wr_en[0]), .eng_tx_wr_data(eng_wdata),
        .busy(k_busy[0]), .owner(k_owner[0]), .err(k_err[0])
    );

    jtag_port_arbiter #(.FAIR(1'b0), .LEN_W(8)) u_prio (
        .clk(clk), .rst(rst),
        .s0_rx_empty(k_rx_empty[1][0]), .s0_rx_rd_en(k_rd_en[1][0]), .s0_rx_rd_data(src_data[0]),
        .s0_tx_full(tx_full[0]), .s0_tx_wr_en(k_wr_en[1][0]), .s0_tx_wr_data(k_wr_data[1][0]),
        .s1_rx_empty(k_rx_empty[1][1]), .s1_rx_rd_en(k_rd_en[1][1]), .s1_rx_rd_data(src_data[1]),
        .s1_tx_full(tx_full[1]), .s1_tx_wr_en(k_wr_en[1][1]), .s1_tx_wr_data(k_wr_data[1][1]),
        .eng_rx_empty(k_eng_rx_empty[1]), .eng_rx_rd_en(k_eng_rd_en[1]), .eng_rx_rd_data(k_eng_rd_data[1]),
        .eng_tx_full(k_eng_tx_full[1]), .eng_tx_wr_en(k_eng_wr_en[1]), .eng_tx_wr_data(eng_wdata),
        .busy(k_busy[1]), .owner(k_owner[1]), .err(k_err[1])
    );

    // Scoreboard queues: expected command bytes seen by the engine, expected {src, byte} returns.
    logic [7:0] exp_cmd [$];
    logic [8:0] exp_ret [$];
    logic [7:0] ret_q [$];
    int         wr_seen [2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int s, input logic [7:0] b);
        mem[s][wp[s]] = b;
        wp[s] = wp[s] + 1;
    endtask

    task automatic load(input int s, input logic [7:0] p, input logic [31:0] c);
        put(s, p);
        for (int i = 0; i < 2 * p; i++) put(s, c[31-8*i -: 8]);
    endtask

    task automatic expect_burst(input int s, input logic [7:0] p, input logic [31:0] c);
        logic [7:0] b0, b1;
        for (int i = 0; i < p; i++) begin
            b0 = c[31-16*i -: 8];
            b1 = c[23-16*i -: 8];
            exp_cmd.push_back(b0);
            exp_cmd.push_back(b1);
            exp_ret.push_back({s[0], b0 ^ b1});
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(!v_busy && src_empty[0] && src_empty[1] && ret_q.size() == 0) && t < 300);
        chk({name, "_timeout"}, (t < 300) ? 32'd1 : 32'd0, 32'd1);
        chk({name, "_cmd_left"}, exp_cmd.size(), 32'd0);
        chk({name, "_ret_left"}, exp_ret.size(), 32'd0);
    endtask

    // Engine model: reads whenever data is offered, returns b0^b1 per command pair.
    initial begin
        logic       rd_pend;
        logic       half;
        logic [7:0] first;
        logic [7:0] e;
        rd_pend = 1'b0;
        half    = 1'b0;
        first   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            eng_wr = 1'b0;
            if (inject) begin
                eng_wr    = 1'b1;
                eng_wdata = 8'h77;
                inject    = 1'b0;
            end else if (eng_en && ret_q.size() > 0 && !v_eng_tx_full) begin
                eng_wr    = 1'b1;
                eng_wdata = ret_q.pop_front();
            end
            eng_rd = eng_en && !v_eng_rx_empty;
            @(negedge clk);
            if (rd_pend) begin
                if (exp_cmd.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL cmd_extra: got %0h expected none", v_eng_rd_data);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_byte", v_eng_rd_data, e);
                end
                if (half) begin
                    ret_q.push_back(first ^ v_eng_rd_data);
                    half = 1'b0;
                end else begin
                    first = v_eng_rd_data;
                    half  = 1'b1;
                end
            end
            rd_pend = eng_rd;
            if (eng_rd) eng_reads++;
        end
    end

    // Monitor: every source return write is popped and compared; source reads must hit data.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (v_wr_en[s]) begin
                    wr_seen[s]++;
                    if (exp_ret.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL ret_unexpected: got src%0d data %0h expected none", s, v_wr_data[s]);
                    end else begin
                        e = exp_ret.pop_front();
                        chk("ret_src", s, {31'd0, e[8]});
                        chk("ret_data", v_wr_data[s], {24'd0, e[7:0]});
                    end
                end
                if (v_rd_en[s]) chk("src_rd_nonempty", {31'd0, src_empty[s]}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, rb, w0, cnt, t;
        rst = 1'b1;
        tx_full[0] = 1'b0;
        tx_full[1] = 1'b0;

        // Both sources hold a burst while in reset; FAIR tie must go s0 first.
        load(0, 8'd1, 32'hA1B2_0000);
        load(1, 8'd1, 32'hC3D4_0000);
        expect_burst(0, 8'd1, 32'hA1B2_0000);
        expect_burst(1, 8'd1, 32'hC3D4_0000);
        repeat (3) @(negedge clk);
        chk("rst_busy", v_busy, 32'd0);
        chk("rst_eng_rx_empty", v_eng_rx_empty, 32'd1);
        chk("rst_eng_tx_full", v_eng_tx_full, 32'd1);
        chk("rst_s0_rd_en", v_rd_en[0], 32'd0);
        chk("rst_s1_rd_en", v_rd_en[1], 32'd0);
        chk("rst_owner", v_owner, 32'd0);
        chk("rst_err", v_err, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        eng_en = 1'b1;
        wait_idle("fair_tie");
        chk("fair_tie_owner", v_owner, 32'd1);

        // Two-pair burst on s0; busy drops the cycle after the 2nd return write.
        r = eng_reads;
        @(posedge clk); #1;
        load(0, 8'd2, 32'h5A5A_00FF);
        expect_burst(0, 8'd2, 32'h5A5A_00FF);
        cnt = 0;
        t = 0;
        while (cnt < 2 && t < 200) begin
            @(negedge clk);
            t++;
            if (v_wr_en[0]) cnt++;
        end
        chk("s0_two_writes_seen", cnt, 32'd2);
        chk("busy_at_2nd_write", v_busy, 32'd1);
        @(negedge clk);
        chk("busy_after_2nd_write", v_busy, 32'd0);
        wait_idle("s0_burst");
        chk("s0_burst_eng_reads", eng_reads - r, 32'd4);

        // Zero header on s1: one header read, no engine traffic, s1 becomes last.
        r = eng_reads;
        rb = rp[1];
        @(posedge clk); #1;
        put(1, 8'h00);
        wait_idle("zero_hdr");
        chk("zero_hdr_eng_reads", eng_reads - r, 32'd0);
        chk("zero_hdr_src_reads", rp[1] - rb, 32'd1);
        chk("zero_hdr_owner", v_owner, 32'd1);

        // Next tie goes to s0.
        @(posedge clk); #1;
        load(0, 8'd1, 32'h1020_0000);
        load(1, 8'd1, 32'h3040_0000);
        expect_burst(0, 8'd1, 32'h1020_0000);
        expect_burst(1, 8'd1, 32'h3040_0000);
        wait_idle("tie_after_zero");

        // s0 header 1 with a single command byte: engine starves, s1 stays blocked.
        r = eng_reads;
        rb = rp[1];
        @(posedge clk); #1;
        put(0, 8'h01);
        put(0, 8'h11);
        load(1, 8'd1, 32'h5566_0000);
        expect_burst(0, 8'd1, 32'h1122_0000);
        expect_burst(1, 8'd1, 32'h5566_0000);
        repeat (12) @(negedge clk);
        chk("starve_eng_rx_empty", v_eng_rx_empty, 32'd1);
        chk("starve_busy", v_busy, 32'd1);
        chk("starve_owner", v_owner, 32'd0);
        chk("starve_eng_reads", eng_reads - r, 32'd1);
        chk("starve_s1_blocked", rp[1] - rb, 32'd0);
        @(posedge clk); #1;
        put(0, 8'h22);
        wait_idle("starve_resume");

        // Owner's return FIFO full holds the engine off; s1's free FIFO does not matter.
        w0 = wr_seen[0];
        @(posedge clk); #1;
        tx_full[0] = 1'b1;
        load(0, 8'd1, 32'hC300_0000);
        expect_burst(0, 8'd1, 32'hC300_0000);
        repeat (12) @(negedge clk);
        chk("full_eng_tx_full", v_eng_tx_full, 32'd1);
        chk("full_busy", v_busy, 32'd1);
        chk("full_no_write", wr_seen[0] - w0, 32'd0);
        @(posedge clk); #1;
        tx_full[0] = 1'b0;
        wait_idle("full_release");
        chk("full_write_landed", wr_seen[0] - w0, 32'd1);

        // Fixed priority instance: s0 holds two bursts, s1 one -> s0, s0, s1.
        @(posedge clk); #1;
        sel = 1;
        load(0, 8'd1, 32'h0102_0000);
        load(0, 8'd1, 32'h0304_0000);
        load(1, 8'd1, 32'h0506_0000);
        expect_burst(0, 8'd1, 32'h0102_0000);
        expect_burst(0, 8'd1, 32'h0304_0000);
        expect_burst(1, 8'd1, 32'h0506_0000);
        wait_idle("prio");
        chk("prio_owner", v_owner, 32'd1);
        @(posedge clk); #1;
        sel = 0;

        // Stray engine write in IDLE sets the sticky error and reaches no source.
        @(negedge clk);
        inject = 1'b1;
        repeat (2) @(negedge clk);
        chk("stray_err", v_err, 32'd1);
        chk("stray_busy", v_busy, 32'd0);

        // Reset in the middle of a grant.
        eng_en = 1'b0;
        @(posedge clk); #1;
        load(0, 8'd2, 32'hDEAD_BEEF);
        repeat (6) @(negedge clk);
        chk("grant_busy", v_busy, 32'd1);
        chk("grant_eng_rx_empty", v_eng_rx_empty, 32'd0);
        chk("grant_err_sticky", v_err, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", v_busy, 32'd0);
        chk("midrst_err", v_err, 32'd0);
        chk("midrst_eng_rx_empty", v_eng_rx_empty, 32'd1);
        chk("midrst_owner", v_owner, 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
